reorder_pingpong: RTL
=====================

REORDER_PINGPONG -- requirements
Module: reorder_pingpong

Interface
REQ-001 Parameter NUM_STAGES, default 4, meaning log2 of NTT frame length N = 2^NUM_STAGES; legal range 3..12.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset is asynchronous and active-low.
REQ-004 pair_valid  input  1  butterfly output pair available.
REQ-005 pair_ready  output  1  pair accepted this cycle when pair_valid && pair_ready.
REQ-006 mode  input  1  0 = reordered write mapping, 1 = natural write mapping; sampled per frame.
REQ-007 wr_en  output  1  write strobe for both wr_addr_top and wr_addr_bot.
REQ-008 wr_bank  output  1  buffer bank targeted by current wr_en.
REQ-009 wr_addr_top, wr_addr_bot  output  NUM_STAGES each  buffer addresses for top/bottom element of the pair.
REQ-010 rd_valid  output  1  rd_addr/rd_bank valid for readout.
REQ-011 rd_ready  input  1  consumer accepts readout beat.
REQ-012 rd_bank  output  1  bank being drained.
REQ-013 rd_addr  output  NUM_STAGES  readout address.
REQ-014 rd_last  output  1  high with final beat of a frame (rd_addr = N-1).
REQ-015 frame_done  output  1  one-cycle pulse after a frame fully drains.

Function
REQ-016 Two banks; per-bank full flag; write pointer wbank, read pointer rbank; pair counter k (NUM_STAGES-1 bits); frame mode register fmode.
REQ-017 pair_ready SHALL equal ~full[wbank] (combinational from registers).
REQ-018 On accept: k increments; wr_en, wr_bank, wr_addr_* register next cycle (1-cycle latency); wr_en low on all non-accept cycles.
REQ-019 fmode SHALL load from mode on the accept with k = 0; the k = 0 pair itself uses the incoming mode; mode changes while k != 0 are ignored.
REQ-020 fmode 0: wr_addr_top = {0, ~k[0], k[NUM_STAGES-2:1]}, wr_addr_bot = {1, same low bits}.
REQ-021 fmode 1: wr_addr_top = {0, k}, wr_addr_bot = {1, k}.
REQ-022 Accept with k = 2^(NUM_STAGES-1)-1: k wraps to 0, full[wbank] set, wbank toggles, all at the same edge.
REQ-023 rd_valid SHALL equal full[rbank]; rd_bank = rbank.
REQ-024 On rd_valid && rd_ready: rd_addr increments modulo N; rd_last = rd_valid && (rd_addr = N-1).
REQ-025 Handshake with rd_last: full[rbank] cleared, rbank toggles, rd_addr wraps to 0, frame_done high next cycle for exactly one cycle.
REQ-026 Set of full[wbank] and clear of full[rbank] in the same cycle SHALL both take effect (always different banks).
REQ-027 rd_ready while rd_valid = 0 SHALL have no effect; pair_valid while pair_ready = 0 SHALL have no effect.
REQ-028 Sustained full-rate traffic (one pair/cycle in, one beat/cycle out) SHALL run with no bubbles across frame boundaries.

Reset
REQ-029 reset_n low SHALL immediately clear k, fmode, wbank, rbank, full[1:0], rd_addr, wr_addr_top, wr_addr_bot, wr_en, wr_bank, frame_done; hence pair_ready = 1, rd_valid = 0, rd_last = 0.
REQ-030 Reset mid-frame SHALL discard partial frames in both banks; first accept after release starts a new frame at k = 0 in bank 0.

Verification (NUM_STAGES = 4)
REQ-031 Reset, mode 0, 8 consecutive pairs -> wr_addr_top 4,0,5,1,6,2,7,3; wr_addr_bot 12,8,13,9,14,10,15,11; wr_bank 0; rd_valid high the cycle after the 8th accept.
REQ-032 mode 1, 8 pairs -> wr_addr_top 0..7, wr_addr_bot 8..15 in order.
REQ-033 rd_ready held 1 after frame -> rd_addr 0..15 on consecutive cycles, rd_last only at 15, frame_done pulse one cycle later, rd_bank then 1.
REQ-034 rd_ready 0, 16 pairs written -> pair_ready low after 16th accept; raise rd_ready -> pair_ready high the cycle after bank 0 drains, next write wr_bank 0.
REQ-035 mode toggled at k = 3 in a mode-0 frame -> remaining addresses follow mode 0; next frame uses mode sampled at its k = 0.
REQ-036 reset_n asserted between clock edges mid-frame -> all outputs reach reset values before next edge; subsequent frame addresses match REQ-031.

Source files
------------

// File: rtl/reorder_pingpong_if.sv
// Handshake/bus bundle for the NTT ping-pong reorder buffer controller.
// The slave side is the controller and the master side is the producer/consumer.
interface reorder_pingpong_if #(parameter int NUM_STAGES = 4);
  logic                  pair_valid;
  logic                  pair_ready;
  logic                  mode;
  logic                  wr_en;
  logic                  wr_bank;
  logic [NUM_STAGES-1:0] wr_addr_top;
  logic [NUM_STAGES-1:0] wr_addr_bot;
  logic                  rd_valid;
  logic                  rd_ready;
  logic                  rd_bank;
  logic [NUM_STAGES-1:0] rd_addr;
  logic                  rd_last;
  logic                  frame_done;

  modport slave (
    input  pair_valid, mode, rd_ready,
    output pair_ready, wr_en, wr_bank, wr_addr_top, wr_addr_bot,
           rd_valid, rd_bank, rd_addr, rd_last, frame_done
  );

  modport master (
    output pair_valid, mode, rd_ready,
    input  pair_ready, wr_en, wr_bank, wr_addr_top, wr_addr_bot,
           rd_valid, rd_bank, rd_addr, rd_last, frame_done
  );
endinterface

// File: rtl/reorder_pingpong.sv
// Ping-pong address generator: butterfly pairs are written into one bank while
// the other bank drains in natural order, one element per beat.
module reorder_pingpong #(
  parameter int NUM_STAGES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  reorder_pingpong_if.slave bus
);
  localparam int KW = NUM_STAGES - 1;
  localparam logic [KW-1:0]         K_MAX = '1;
  localparam logic [KW-1:0]         K_ONE = KW'(1);
  localparam logic [NUM_STAGES-1:0] A_MAX = '1;
  localparam logic [NUM_STAGES-1:0] A_ONE = NUM_STAGES'(1);

  logic [KW-1:0]         r_k;
  logic                  r_fmode;
  logic                  r_wbank;
  logic                  r_rbank;
  logic [1:0]            r_full;
  logic [NUM_STAGES-1:0] r_rd_addr;
  logic                  r_wr_en;
  logic                  r_wr_bank;
  logic [NUM_STAGES-1:0] r_wr_addr_top;
  logic [NUM_STAGES-1:0] r_wr_addr_bot;
  logic                  r_frame_done;

  logic                  w_accept;
  logic                  w_mode;
  logic [KW-1:0]         w_lo;
  logic                  w_wr_wrap;
  logic                  w_rd_hs;
  logic                  w_rd_wrap;
  logic [1:0]            w_full_nxt;

  assign w_accept  = bus.pair_valid & ~r_full[r_wbank];
  // The first pair of a frame must already use the incoming mode.
  assign w_mode    = (r_k == '0) ? bus.mode : r_fmode;
  assign w_lo      = w_mode ? r_k : {~r_k[0], r_k[KW-1:1]};
  assign w_wr_wrap = w_accept & (r_k == K_MAX);
  assign w_rd_hs   = r_full[r_rbank] & bus.rd_ready;
  assign w_rd_wrap = w_rd_hs & (r_rd_addr == A_MAX);

  // Set and clear never hit the same bank: a set needs it empty, a clear needs it full.
  always_comb begin
    w_full_nxt = r_full;
    if (w_rd_wrap) w_full_nxt[r_rbank] = 1'b0;
    if (w_wr_wrap) w_full_nxt[r_wbank] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_k           <= '0;
      r_fmode       <= 1'b0;
      r_wbank       <= 1'b0;
      r_rbank       <= 1'b0;
      r_full        <= 2'b00;
      r_rd_addr     <= '0;
      r_wr_en       <= 1'b0;
      r_wr_bank     <= 1'b0;
      r_wr_addr_top <= '0;
      r_wr_addr_bot <= '0;
      r_frame_done  <= 1'b0;
    end else begin
      r_wr_en      <= w_accept;
      r_frame_done <= w_rd_wrap;
      r_full       <= w_full_nxt;
      if (w_accept) begin
        r_k           <= r_k + K_ONE;
        r_wr_bank     <= r_wbank;
        r_wr_addr_top <= {1'b0, w_lo};
        r_wr_addr_bot <= {1'b1, w_lo};
        if (r_k == '0) r_fmode <= bus.mode;
        if (w_wr_wrap) r_wbank <= ~r_wbank;
      end
      if (w_rd_hs) begin
        r_rd_addr <= r_rd_addr + A_ONE;
        if (w_rd_wrap) r_rbank <= ~r_rbank;
      end
    end
  end

  assign bus.pair_ready  = ~r_full[r_wbank];
  assign bus.wr_en       = r_wr_en;
  assign bus.wr_bank     = r_wr_bank;
  assign bus.wr_addr_top = r_wr_addr_top;
  assign bus.wr_addr_bot = r_wr_addr_bot;
  assign bus.rd_valid    = r_full[r_rbank];
  assign bus.rd_bank     = r_rbank;
  assign bus.rd_addr     = r_rd_addr;
  assign bus.rd_last     = r_full[r_rbank] & (r_rd_addr == A_MAX);
  assign bus.frame_done  = r_frame_done;
endmodule
